// File: rtl/io_stage_if.sv
// io_stage_if: bus structs and handshake signals between EX, io_stage, WB, data SRAM and ID
//   ex_to_io_bus            EX -> IO instruction payload
//   io_allow_in             IO -> EX accept
//   wb_allow_in             WB -> IO accept
//   data_sram_data_ok       SRAM -> IO one-cycle read-data pulse
//   data_sram_rdata         SRAM -> IO read data
//   io_to_wb_bus            IO -> WB result and register-write control
//   io_to_id_back_pass_bus  IO -> ID forwarding and load-use pending flag
//   modports: master = surrounding pipeline side, slave = io_stage
interface io_stage_if;
   typedef struct packed {
      logic        valid;
      logic [31:0] program_count;
      logic [31:0] alu_result;
      logic        load_enabled;
      logic [2:0]  load_op;
      logic        register_file_write_enabled;
      logic [4:0]  register_file_address;
   } ex_to_io_t;
   typedef struct packed {
      logic        valid;
      logic [31:0] program_count;
      logic        register_file_write_enabled;
      logic [4:0]  register_file_address;
      logic [31:0] final_result;
   } io_to_wb_t;
   typedef struct packed {
      logic        valid;
      logic [4:0]  write_register;
      logic [31:0] write_data;
      logic        data_pending;
   } io_to_id_t;
   ex_to_io_t   ex_to_io_bus;
   logic        io_allow_in;
   logic        wb_allow_in;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   io_to_wb_t   io_to_wb_bus;
   io_to_id_t   io_to_id_back_pass_bus;
   modport master (
      output ex_to_io_bus, wb_allow_in, data_sram_data_ok, data_sram_rdata,
      input  io_allow_in, io_to_wb_bus, io_to_id_back_pass_bus
   );
   modport slave (
      input  ex_to_io_bus, wb_allow_in, data_sram_data_ok, data_sram_rdata,
      output io_allow_in, io_to_wb_bus, io_to_id_back_pass_bus
   );
endinterface

// File: rtl/io_stage.sv
// io_stage: MIPS memory-response stage; waits for load data, extracts/extends it and hands results to WB
//   clock  stage clock
//   reset  synchronous, active-high
//   bus    io_stage_if.slave: EX payload in, IO/WB handshakes, SRAM response, WB bus and ID back-pass out
module io_stage (
   input  logic      clock,
   input  logic      reset,
   io_stage_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_DATA, HOLD} state_t;
   state_t      state, state_next;
   logic        io_valid;
   logic [31:0] pc_r, alu_r, rdata_buffer;
   logic        load_r, we_r;
   logic [2:0]  op_r;
   logic [4:0]  addr_r;
   logic        data_ok, io_ready_go, allow_in;
   logic [31:0] load_src, load_data, final_result;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   // A data_ok outside WAIT_DATA is stray and must not disturb the stage
   assign data_ok     = bus.data_sram_data_ok && state == WAIT_DATA;
   assign io_ready_go = !load_r || data_ok || state == HOLD;
   assign allow_in    = !io_valid || (io_ready_go && bus.wb_allow_in);
   always_comb begin
      state_next = state;
      if (allow_in)
         state_next = bus.ex_to_io_bus.valid && bus.ex_to_io_bus.load_enabled ? WAIT_DATA : IDLE;
      else if (data_ok)
         state_next = HOLD;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         io_valid     <= 1'b0;
         state        <= IDLE;
         rdata_buffer <= 32'd0;
      end else begin
         state <= state_next;
         if (allow_in) io_valid <= bus.ex_to_io_bus.valid;
         if (data_ok && !allow_in) rdata_buffer <= bus.data_sram_rdata;
      end
   end
   always_ff @(posedge clock)
      if (allow_in && bus.ex_to_io_bus.valid) begin
         pc_r   <= bus.ex_to_io_bus.program_count;
         alu_r  <= bus.ex_to_io_bus.alu_result;
         load_r <= bus.ex_to_io_bus.load_enabled;
         op_r   <= bus.ex_to_io_bus.load_op;
         we_r   <= bus.ex_to_io_bus.register_file_write_enabled;
         addr_r <= bus.ex_to_io_bus.register_file_address;
      end
   // Halfword select ignores alu_result[0]; misalignment is trapped in EX
   always_comb begin
      load_src     = data_ok ? bus.data_sram_rdata : rdata_buffer;
      byte_sel     = load_src[{alu_r[1:0], 3'b000} +: 8];
      half_sel     = alu_r[1] ? load_src[31:16] : load_src[15:0];
      load_data    = op_r == 3'd1 ? {{24{byte_sel[7]}}, byte_sel}
                   : op_r == 3'd2 ? {24'd0, byte_sel}
                   : op_r == 3'd3 ? {{16{half_sel[15]}}, half_sel}
                   : op_r == 3'd4 ? {16'd0, half_sel}
                   : load_src;
      final_result = load_r ? load_data : alu_r;
   end
   assign bus.io_allow_in  = allow_in;
   assign bus.io_to_wb_bus = '{
      valid:                       io_valid && io_ready_go,
      program_count:               pc_r,
      register_file_write_enabled: we_r && io_valid,
      register_file_address:       addr_r,
      final_result:                final_result
   };
   assign bus.io_to_id_back_pass_bus = '{
      valid:          1'b1,
      write_register: io_valid && we_r ? addr_r : 5'd0,
      write_data:     final_result,
      data_pending:   io_valid && load_r && !io_ready_go
   };
endmodule
